// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port feature memory between pipeline stages,
// with bounded lock bursts and a one-hot read-data valid returned one cycle after the grant.
module mem_arbiter #(
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned MAX_BURST = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ-1:0]           lock,
    input  logic [N_REQ-1:0]           we,
    input  logic [N_REQ*ADDR_W-1:0]    addr,
    input  logic [N_REQ*DATA_W-1:0]    wdata,
    output logic [N_REQ-1:0]           gnt,
    output logic [N_REQ-1:0]           rvalid,
    output logic [DATA_W-1:0]          rdata,
    output logic                       mem_en,
    output logic                       mem_we,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [DATA_W-1:0]          mem_wdata,
    input  logic [DATA_W-1:0]          mem_rdata
);

    localparam int unsigned PTR_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned BURST_W = $clog2(MAX_BURST + 1);

    typedef enum logic {ARB, OWN} mode_t;

    mode_t              mode;
    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   owner;
    logic [BURST_W-1:0] burst;

    logic               grant_any;
    logic [PTR_W-1:0]   grant_idx;
    logic               lock_next;

    // Rotating scan from ptr; descending loop so the nearest requester is written last.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        for (int unsigned i = N_REQ; i > 0; i--) begin
            if (req[PTR_W'((32'(ptr) + i - 1) % N_REQ)]) begin
                grant_any = 1'b1;
                grant_idx = PTR_W'((32'(ptr) + i - 1) % N_REQ);
            end
        end
        if (mode == OWN && req[owner]) begin
            grant_any = 1'b1;
            grant_idx = owner;
        end
        if (rst) begin
            grant_any = 1'b0;
            grant_idx = '0;
        end
    end

    // Memory port driven straight from the granted requester; idle port is all-zero.
    always_comb begin
        gnt       = '0;
        mem_en    = grant_any;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        lock_next = 1'b0;
        if (grant_any) begin
            gnt[grant_idx] = 1'b1;
            mem_we         = we[grant_idx];
            mem_addr       = addr[32'(grant_idx)*ADDR_W +: ADDR_W];
            mem_wdata      = wdata[32'(grant_idx)*DATA_W +: DATA_W];
            lock_next      = lock[grant_idx] && ((32'(burst) + 1) < MAX_BURST);
        end
    end

    assign rdata = mem_rdata;

    // Pointer only advances on a released grant, so a capped owner drops to lowest priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr    <= '0;
            mode   <= ARB;
            owner  <= '0;
            burst  <= '0;
            rvalid <= '0;
        end else begin
            rvalid <= gnt & ~we;
            if (lock_next) begin
                mode  <= OWN;
                owner <= grant_idx;
                burst <= burst + BURST_W'(1);
            end else begin
                mode  <= ARB;
                burst <= '0;
                if (grant_any) begin
                    ptr <= PTR_W'((32'(grant_idx) + 1) % N_REQ);
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed scenarios plus randomized traffic against a
// behavioural arbitration/memory model.
module tb_mem_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned AW = 10;
    localparam int unsigned DW = 16;
    localparam int unsigned MB = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req, lock, we;
    logic [N*AW-1:0]   addr;
    logic [N*DW-1:0]   wdata;
    logic [N-1:0]      gnt, rvalid;
    logic [DW-1:0]     rdata;
    logic              mem_en, mem_we;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic [DW-1:0]     mem_rdata;

    mem_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
        .clk(clk), .rst(rst), .req(req), .lock(lock), .we(we), .addr(addr), .wdata(wdata),
        .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Single-port memory attached to the DUT port.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    typedef struct {
        logic [N-1:0]  gnt;
        logic          en;
        logic          we;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        bit            chk_rv;
        logic [N-1:0]  rv;
        logic [DW-1:0] rd;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_pass = 0;

    // Reference model state
    int            m_ptr, m_owner, m_burst, last_k;
    bit            m_own;
    logic [DW-1:0] shadow [0:(1<<AW)-1];
    logic [N-1:0]  p_rv;
    logic [DW-1:0] p_rd;
    logic [AW-1:0] t_addr  [N];
    logic [DW-1:0] t_wdata [N];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Drive one cycle and push the model's expectation for it.
    task automatic step(input bit r, input logic [N-1:0] rq, input logic [N-1:0] lk,
                        input logic [N-1:0] w);
        exp_t e;
        int   k;
        @(posedge clk); #1;
        rst = r; req = rq; lock = lk; we = w;
        for (int i = 0; i < N; i++) begin
            addr[i*AW +: AW]  = t_addr[i];
            wdata[i*DW +: DW] = t_wdata[i];
        end
        e.chk_rv = !r;
        e.rv = p_rv;
        e.rd = p_rd;
        k = -1;
        if (!r) begin
            if (m_own && rq[m_owner]) k = m_owner;
            else
                for (int i = 0; i < N; i++)
                    if (k < 0 && rq[(m_ptr + i) % N]) k = (m_ptr + i) % N;
        end
        e.gnt = (k >= 0) ? N'(1) << k : '0;
        e.en  = (k >= 0);
        e.we  = (k >= 0) ? w[k] : 1'b0;
        e.a   = (k >= 0) ? t_addr[k] : '0;
        e.d   = (k >= 0) ? t_wdata[k] : '0;
        p_rv = '0;
        if (r) begin
            m_ptr = 0; m_own = 0; m_owner = 0; m_burst = 0;
        end else if (k >= 0) begin
            if (w[k]) shadow[t_addr[k]] = t_wdata[k];
            else begin
                p_rv = N'(1) << k;
                p_rd = shadow[t_addr[k]];
            end
            if (lk[k] && m_burst + 1 < MB) begin
                m_own = 1; m_owner = k; m_burst++;
            end else begin
                m_own = 0; m_burst = 0; m_ptr = (k + 1) % N;
            end
        end else begin
            m_own = 0; m_burst = 0;
        end
        last_k = k;
        sb.push_back(e);
    endtask

    // Monitor: compare every driven cycle against its queued expectation.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("gnt", 32'(gnt), 32'(e.gnt));
            chk("mem_en", 32'(mem_en), 32'(e.en));
            chk("mem_we", 32'(mem_we), 32'(e.we));
            chk("mem_addr", 32'(mem_addr), 32'(e.a));
            chk("mem_wdata", 32'(mem_wdata), 32'(e.d));
            if (e.chk_rv) begin
                chk("rvalid", 32'(rvalid), 32'(e.rv));
                if (e.rv != '0) chk("rdata", 32'(rdata), 32'(e.rd));
            end
        end
    end

    task automatic seq_check(input string nm, input logic [N-1:0] rq, input logic [N-1:0] lk,
                             input int cnt, input logic [N-1:0] exp_seq[$]);
        for (int c = 0; c < cnt; c++) begin
            step(0, rq, lk, '0);
            @(negedge clk);
            chk(nm, 32'(gnt), 32'(exp_seq[c]));
        end
    endtask

    logic [N-1:0] seq[$];
    bit           pend [N];
    logic [N-1:0] r_req, r_lock, r_we;
    bit           rs;

    initial begin
        rst = 1'b1; req = '0; lock = '0; we = '0; addr = '0; wdata = '0;
        m_ptr = 0; m_own = 0; m_owner = 0; m_burst = 0; p_rv = '0; p_rd = '0; last_k = -1;
        for (int i = 0; i < (1 << AW); i++) begin
            mem[i] = DW'($urandom);
            shadow[i] = mem[i];
        end
        mem[5] = 16'hBEEF; shadow[5] = 16'hBEEF;
        for (int i = 0; i < N; i++) begin t_addr[i] = '0; t_wdata[i] = '0; end

        // Reset: nothing granted even with all requests up
        step(1, '0, '0, '0);
        step(1, 4'hF, '0, '0);
        @(negedge clk);
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_mem_en", 32'(mem_en), 32'h0);

        // Single read by requester 2
        t_addr[2] = 10'h005;
        step(0, 4'b0100, '0, '0);
        @(negedge clk);
        chk("rd_gnt", 32'(gnt), 32'h4);
        chk("rd_addr", 32'(mem_addr), 32'h5);
        step(0, '0, '0, '0);
        @(negedge clk);
        chk("rd_rvalid", 32'(rvalid), 32'h4);
        chk("rd_rdata", 32'(rdata), 32'hBEEF);

        // Fairness from reset
        step(1, '0, '0, '0);
        seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        seq_check("fair", 4'hF, '0, 5, seq);

        // Capped burst by locking requester 0
        step(1, '0, '0, '0);
        seq = '{};
        for (int i = 0; i < 8; i++) seq.push_back(4'b0001);
        seq.push_back(4'b0010); seq.push_back(4'b0100); seq.push_back(4'b1000);
        seq.push_back(4'b0001);
        seq_check("burst", 4'hF, 4'b0001, 12, seq);

        // Owner release mid-burst
        step(1, '0, '0, '0);
        seq = '{4'b0001, 4'b0010, 4'b0010};
        seq_check("own", 4'b0011, 4'b0010, 3, seq);
        step(0, 4'b0001, 4'b0010, '0);
        @(negedge clk);
        chk("release_gnt", 32'(gnt), 32'h1);
        step(0, 4'b0011, '0, '0);
        @(negedge clk);
        chk("after_release", 32'(gnt), 32'h2);

        // Write then read back by requester 3
        t_addr[3] = 10'h3FF; t_wdata[3] = 16'h1234;
        step(0, 4'b1000, '0, 4'b1000);
        @(negedge clk);
        chk("wr_mem_we", 32'(mem_we), 32'h1);
        step(0, 4'b1000, '0, '0);
        @(negedge clk);
        chk("rb_mem_we", 32'(mem_we), 32'h0);
        step(0, '0, '0, '0);
        @(negedge clk);
        chk("rb_rvalid", 32'(rvalid), 32'h8);
        chk("rb_rdata", 32'(rdata), 32'h1234);

        // Reset in the middle of a locked read burst
        step(1, '0, '0, '0);
        t_addr[0] = 10'h005;
        for (int i = 0; i < 3; i++) step(0, 4'b0001, 4'b0001, '0);
        step(1, 4'hF, 4'b0001, '0);
        @(negedge clk);
        chk("mrst_gnt", 32'(gnt), 32'h0);
        chk("mrst_mem_en", 32'(mem_en), 32'h0);
        step(0, 4'hF, '0, '0);
        @(negedge clk);
        chk("mrst_rvalid", 32'(rvalid), 32'h0);
        chk("mrst_gnt1", 32'(gnt), 32'h1);
        step(0, 4'hF, '0, '0);
        @(negedge clk);
        chk("mrst_gnt2", 32'(gnt), 32'h2);

        // Randomized traffic honouring the hold-until-grant protocol
        for (int i = 0; i < N; i++) pend[i] = 0;
        r_lock = '0; r_we = '0;
        for (int c = 0; c < 2000; c++) begin
            r_req = '0;
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(1, 0) == 1) begin
                    pend[i]    = 1;
                    t_addr[i]  = AW'($urandom_range(15, 0));
                    t_wdata[i] = DW'($urandom);
                    r_we[i]    = 1'($urandom_range(1, 0));
                    r_lock[i]  = ($urandom_range(3, 0) != 0);
                end
                r_req[i] = pend[i];
            end
            rs = ($urandom_range(99, 0) == 0);
            step(rs, r_req, r_lock, r_we);
            if (!rs && last_k >= 0) pend[last_k] = 0;
        end
        step(0, '0, '0, '0);

        for (int i = 0; i < 8 && sb.size() > 0; i++) @(negedge clk);
        @(negedge clk);
        chk("sb_drain", 32'(sb.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
